// File: rtl/datapath_control_seq.sv
// ---------------------------------------------------------------------------
// datapath_control_seq
//
// Purpose:
//   Control sequencer for the datapath register-transfer block. A one-shot
//   start command plus opcode is turned into a timed sequence of steps
//   (T0..T3) on the bus-drive and register-load strobes. This block drives
//   the datapath control interface.
//
//   Opcodes (one cycle per step):
//     00 LDA   : T0 -> DONE             RA <= imm_a
//     01 ADDB  : T1 -> T2 -> DONE       RB <= RA + imm_b
//     10 LDADD : T0 -> T1 -> T2 -> DONE RA <= imm_a, RB <= imm_a + imm_b
//     11 MOVBA : T3 -> DONE             RA <= RB
//
// Ports:
//   clock              system clock, rising-edge active
//   clear              synchronous active-high reset
//   start              command request, sampled only in IDLE
//   opcode[1:0]        operation selector, latched with start
//   imm_a[DATA_WIDTH]  immediate loaded into RA, latched with start
//   imm_b[DATA_WIDTH]  addend for RA + imm_b, latched with start
//   RAin/RBin/RZin     register load strobes
//   RAout/RBout/RZout  bus drive strobes (at most one high per cycle)
//   AddImmediate       adder immediate operand, nonzero only in T1
//   RegisterAImmediate immediate written into RA, nonzero only in T0
//   busy               high in T0..T3
//   done               one-cycle completion pulse (DONE state)
//   present_state[3:0] current state code, for debug
// ---------------------------------------------------------------------------
module datapath_control_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [1:0]            opcode,
    input  logic [DATA_WIDTH-1:0] imm_a,
    input  logic [DATA_WIDTH-1:0] imm_b,
    output logic                  RAin,
    output logic                  RBin,
    output logic                  RZin,
    output logic                  RAout,
    output logic                  RBout,
    output logic                  RZout,
    output logic [DATA_WIDTH-1:0] AddImmediate,
    output logic [DATA_WIDTH-1:0] RegisterAImmediate,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            present_state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        DONE = 4'd5
    } state_t;

    localparam logic [1:0] OP_LDA   = 2'b00;
    localparam logic [1:0] OP_ADDB  = 2'b01;
    localparam logic [1:0] OP_LDADD = 2'b10;
    localparam logic [1:0] OP_MOVBA = 2'b11;

    state_t                state_r;
    state_t                state_nx;
    logic [1:0]            op_r;
    logic [DATA_WIDTH-1:0] imm_a_r;
    logic [DATA_WIDTH-1:0] imm_b_r;

    logic                  accept;
    logic [1:0]            op_nx;
    logic [DATA_WIDTH-1:0] imm_a_nx;
    logic [DATA_WIDTH-1:0] imm_b_nx;

    // Command acceptance and the values that will be in effect next cycle.
    // On the accepting edge the live inputs are used so the first step's
    // immediate is already correct in the cycle right after start.
    assign accept   = (state_r == IDLE) && start;
    assign op_nx    = accept ? opcode : op_r;
    assign imm_a_nx = accept ? imm_a  : imm_a_r;
    assign imm_b_nx = accept ? imm_b  : imm_b_r;

    always_comb begin
        state_nx = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_LDA:   state_nx = T0;
                        OP_ADDB:  state_nx = T1;
                        OP_LDADD: state_nx = T0;
                        OP_MOVBA: state_nx = T3;
                        default:  state_nx = IDLE;
                    endcase
                end else begin
                    state_nx = IDLE;
                end
            end
            T0:      state_nx = (op_r == OP_LDADD) ? T1 : DONE;
            T1:      state_nx = T2;
            T2:      state_nx = DONE;
            T3:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            // Unreachable codes fall back to IDLE.
            default: state_nx = IDLE;
        endcase
    end

    // State, command latch and outputs. Outputs are registered from the next
    // state so each strobe changes exactly at the state boundary.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r            <= IDLE;
            op_r               <= '0;
            imm_a_r            <= '0;
            imm_b_r            <= '0;
            RAin               <= 1'b0;
            RBin               <= 1'b0;
            RZin               <= 1'b0;
            RAout              <= 1'b0;
            RBout              <= 1'b0;
            RZout              <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            AddImmediate       <= '0;
            RegisterAImmediate <= '0;
        end else begin
            state_r <= state_nx;
            if (accept) begin
                op_r    <= op_nx;
                imm_a_r <= imm_a_nx;
                imm_b_r <= imm_b_nx;
            end
            RAin               <= (state_nx == T0) || (state_nx == T3);
            RBin               <= (state_nx == T2);
            RZin               <= (state_nx == T1);
            RAout              <= (state_nx == T1);
            RBout              <= (state_nx == T3);
            RZout              <= (state_nx == T2);
            busy               <= (state_nx == T0) || (state_nx == T1) ||
                                  (state_nx == T2) || (state_nx == T3);
            done               <= (state_nx == DONE);
            AddImmediate       <= (state_nx == T1) ? imm_b_nx : '0;
            RegisterAImmediate <= (state_nx == T0) ? imm_a_nx : '0;
        end
    end

    assign present_state = state_r;

endmodule

// File: tb/tb_datapath_control_seq.sv
// ---------------------------------------------------------------------------
// tb_datapath_control_seq
//
// Directed bench for datapath_control_seq. A small register-transfer model
// (RA, RB, RZ and a shared bus) is driven from the strobes so the end effect
// of each command can be checked against hand-computed register values.
// ---------------------------------------------------------------------------
module tb_datapath_control_seq;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [1:0]    opcode;
    logic [DW-1:0] imm_a;
    logic [DW-1:0] imm_b;
    logic          RAin, RBin, RZin, RAout, RBout, RZout;
    logic [DW-1:0] AddImmediate;
    logic [DW-1:0] RegisterAImmediate;
    logic          busy;
    logic          done;
    logic [3:0]    present_state;

    int total = 0;
    int bad   = 0;

    datapath_control_seq #(.DATA_WIDTH(DW)) dut (
        .clock              (clock),
        .clear              (clear),
        .start              (start),
        .opcode             (opcode),
        .imm_a              (imm_a),
        .imm_b              (imm_b),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .RAout              (RAout),
        .RBout              (RBout),
        .RZout              (RZout),
        .AddImmediate       (AddImmediate),
        .RegisterAImmediate (RegisterAImmediate),
        .busy               (busy),
        .done               (done),
        .present_state      (present_state)
    );

    always #5 clock = ~clock;

    // Register-transfer model of the attached datapath.
    logic [DW-1:0] ra = '0;
    logic [DW-1:0] rb = '0;
    logic [DW-1:0] rz = '0;
    logic [DW-1:0] bus;

    always_comb begin
        bus = '0;
        if (RAout)      bus = ra;
        else if (RBout) bus = rb;
        else if (RZout) bus = rz;
    end

    always @(posedge clock) begin
        if (RAin) ra <= bus + RegisterAImmediate;
        if (RBin) rb <= bus;
        if (RZin) rz <= bus + AddImmediate;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_T0   = 6'b100000;  // RAin
    localparam logic [5:0] S_T1   = 6'b001100;  // RZin, RAout
    localparam logic [5:0] S_T2   = 6'b010001;  // RBin, RZout
    localparam logic [5:0] S_T3   = 6'b100010;  // RAin, RBout

    task automatic chk_out(input string tag, input logic [3:0] st, input logic [5:0] strb,
                           input logic b, input logic d,
                           input logic [DW-1:0] ai, input logic [DW-1:0] ri);
        chk({tag, ".state"}, 32'(present_state), 32'(st));
        chk({tag, ".strb"},  32'({RAin, RBin, RZin, RAout, RBout, RZout}), 32'(strb));
        chk({tag, ".busy"},  32'(busy), 32'(b));
        chk({tag, ".done"},  32'(done), 32'(d));
        chk({tag, ".addimm"}, AddImmediate, ai);
        chk({tag, ".raimm"},  RegisterAImmediate, ri);
        chk({tag, ".bus1hot"}, 32'($countones({RAout, RBout, RZout}) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear  = 1'b1;
        start  = 1'b1;
        opcode = 2'b10;
        imm_a  = 32'h7;
        imm_b  = 32'h9;

        // Reset with start asserted: nothing accepted.
        tick();
        tick();
        chk_out("rst", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);
        clear = 1'b0;
        start = 1'b0;
        tick();
        chk_out("rst_idle", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);

        // LDADD 5 + 5; inputs scrambled after the latch edge.
        start = 1'b1; opcode = 2'b10; imm_a = 32'h5; imm_b = 32'h5;
        tick();
        start = 1'b0; opcode = 2'b00; imm_a = 32'h0; imm_b = 32'h0;
        chk_out("ldadd_t0", 4'd1, S_T0, 1'b1, 1'b0, 32'h0, 32'h5);
        tick();
        chk_out("ldadd_t1", 4'd2, S_T1, 1'b1, 1'b0, 32'h5, 32'h0);
        tick();
        chk_out("ldadd_t2", 4'd3, S_T2, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk_out("ldadd_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("ldadd_rb", rb, 32'hA);
        chk("ldadd_ra", ra, 32'h5);
        tick();
        chk_out("ldadd_idle", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);

        // LDA 0x1234 issued in the first IDLE cycle.
        start = 1'b1; opcode = 2'b00; imm_a = 32'h1234;
        tick();
        start = 1'b0;
        chk_out("lda_t0", 4'd1, S_T0, 1'b1, 1'b0, 32'h0, 32'h1234);
        tick();
        chk_out("lda_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("lda_ra", ra, 32'h1234);
        tick();
        chk_out("lda_idle", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);

        // ADDB 0xFFFFFFFF: wraps to 0x1233.
        start = 1'b1; opcode = 2'b01; imm_b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        chk_out("addb_t1", 4'd2, S_T1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick();
        chk_out("addb_t2", 4'd3, S_T2, 1'b1, 1'b0, '0, '0);
        tick();
        chk_out("addb_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("addb_rb", rb, 32'h1233);
        tick();

        // MOVBA: RA <= RB.
        start = 1'b1; opcode = 2'b11;
        tick();
        start = 1'b0;
        chk_out("movba_t3", 4'd4, S_T3, 1'b1, 1'b0, '0, '0);
        tick();
        chk_out("movba_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("movba_ra", ra, 32'h1233);
        tick();

        // start held through ADDB, opcode switched to LDA mid-run.
        start = 1'b1; opcode = 2'b01; imm_a = 32'h55; imm_b = 32'h2;
        tick();
        chk_out("hold_t1", 4'd2, S_T1, 1'b1, 1'b0, 32'h2, '0);
        opcode = 2'b00;
        tick();
        chk_out("hold_t2", 4'd3, S_T2, 1'b1, 1'b0, '0, '0);
        tick();
        chk_out("hold_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("hold_rb", rb, 32'h1235);
        tick();
        chk_out("hold_idle", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);
        tick();
        start = 1'b0;
        chk_out("hold_lda_t0", 4'd1, S_T0, 1'b1, 1'b0, '0, 32'h55);
        tick();
        chk_out("hold_lda_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        tick();

        // clear during T1 of LDADD aborts with no done pulse.
        start = 1'b1; opcode = 2'b10; imm_a = 32'h3; imm_b = 32'h4;
        tick();
        start = 1'b0;
        chk_out("abort_t0", 4'd1, S_T0, 1'b1, 1'b0, '0, 32'h3);
        tick();
        chk_out("abort_t1", 4'd2, S_T1, 1'b1, 1'b0, 32'h4, '0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_out("abort_clr", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);
        tick();
        chk_out("abort_nodone", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);

        // Normal LDA after the abort.
        start = 1'b1; opcode = 2'b00; imm_a = 32'h9;
        tick();
        start = 1'b0;
        chk_out("post_t0", 4'd1, S_T0, 1'b1, 1'b0, '0, 32'h9);
        tick();
        chk_out("post_done", 4'd5, S_NONE, 1'b0, 1'b1, '0, '0);
        chk("post_ra", ra, 32'h9);
        tick();
        chk_out("post_idle", 4'd0, S_NONE, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
